usr_sipo_receiver: RTL and testbench

Serial-in/parallel-out receiver for the far end of the universal shift register's serial stream. It collects `WIDTH` serial bits, strobed individually, into a word and presents each completed word on a parallel output behind a valid/ready handshake. Shift direction is selectable per word, matching the register's left-shift and right-shift modes. It has a single-word holding register and a sticky overrun flag.

---
 rtl/usr_sipo_receiver.sv | 149 ++++++++++++++
 tb/tb_usr_sipo_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/usr_sipo_receiver.sv
// Serial-in/parallel-out receiver: assembles WIDTH strobed bits (MSB- or LSB-first)
// into a word held behind a valid/ready handshake, with a sticky overrun flag.
module usr_sipo_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SI,
  input  logic             SI_VLD,
  input  logic             DIR,
  input  logic             CLR,
  input  logic             PO_RDY,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VLD,
  output logic             BUSY,
  output logic             OVR
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  logic [WIDTH-1:0] sreg_r, sreg_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [WIDTH-1:0] po_r, po_nxt_s;
  logic             po_vld_r, po_vld_nxt_s;
  logic             ovr_r, ovr_nxt_s;
  logic             busy_r, busy_nxt_s;
  state_t           state_s;
  logic             shift_right_s;
  logic [WIDTH-1:0] shifted_s;
  logic             complete_s;
  logic             free_s;

  function automatic logic [WIDTH-1:0] shift_bit(input logic [WIDTH-1:0] cur,
                                                 input logic bit_in,
                                                 input logic right);
    logic [WIDTH-1:0] res;
    if (right) begin
      res = {bit_in, cur[WIDTH-1:1]};
    end else begin
      res = {cur[WIDTH-2:0], bit_in};
    end
    return res;
  endfunction

  // The bit counter doubles as the state: zero means no word is in progress.
  assign state_s       = (cnt_r == '0) ? ST_IDLE : ST_SHIFT;
  assign shift_right_s = (state_s == ST_IDLE) ? DIR : dir_r;
  assign shifted_s     = shift_bit(sreg_r, SI, shift_right_s);
  assign complete_s    = SI_VLD && (cnt_r == CNT_LAST);
  assign free_s        = !po_vld_r || PO_RDY;

  // State register for the whole receiver.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg_r   <= '0;
      cnt_r    <= '0;
      dir_r    <= 1'b0;
      po_r     <= '0;
      po_vld_r <= 1'b0;
      ovr_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      sreg_r   <= sreg_nxt_s;
      cnt_r    <= cnt_nxt_s;
      dir_r    <= dir_nxt_s;
      po_r     <= po_nxt_s;
      po_vld_r <= po_vld_nxt_s;
      ovr_r    <= ovr_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  // Next-state logic: clear wins, then bit shifting, then completion/accept.
  always_comb begin
    sreg_nxt_s   = sreg_r;
    cnt_nxt_s    = cnt_r;
    dir_nxt_s    = dir_r;
    po_nxt_s     = po_r;
    po_vld_nxt_s = po_vld_r;
    ovr_nxt_s    = ovr_r;
    if (CLR) begin
      sreg_nxt_s   = '0;
      cnt_nxt_s    = '0;
      dir_nxt_s    = 1'b0;
      po_nxt_s     = '0;
      po_vld_nxt_s = 1'b0;
      ovr_nxt_s    = 1'b0;
    end else begin
      if (SI_VLD) begin
        sreg_nxt_s = shifted_s;
        case (state_s)
          ST_IDLE: begin
            dir_nxt_s = DIR;
            cnt_nxt_s = CNT_ONE;
          end
          ST_SHIFT: begin
            if (complete_s) begin
              cnt_nxt_s = '0;
            end else begin
              cnt_nxt_s = cnt_r + CNT_ONE;
            end
          end
          default: begin
            cnt_nxt_s = '0;
          end
        endcase
      end else begin
        sreg_nxt_s = sreg_r;
      end
      // A completion into a full, unaccepted holding register is dropped.
      if (complete_s) begin
        if (free_s) begin
          po_nxt_s     = shifted_s;
          po_vld_nxt_s = 1'b1;
        end else begin
          ovr_nxt_s = 1'b1;
        end
      end else if (po_vld_r && PO_RDY) begin
        po_vld_nxt_s = 1'b0;
      end else begin
        po_vld_nxt_s = po_vld_r;
      end
    end
  end

  // Output decode: BUSY is registered from the next bit count.
  always_comb begin
    busy_nxt_s = 1'b0;
    if (cnt_nxt_s != '0) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  assign PO     = po_r;
  assign PO_VLD = po_vld_r;
  assign BUSY   = busy_r;
  assign OVR    = ovr_r;

endmodule

// File: tb/tb_usr_sipo_receiver.sv
// Self-checking bench for usr_sipo_receiver: table vectors, directed corner
// sequences and random traffic against a queue-based word model.
module tb_usr_sipo_receiver;

  logic       CLK, RST, SI, SI_VLD, DIR, CLR, PO_RDY;
  logic [7:0] PO;
  logic       PO_VLD, BUSY, OVR;

  int n_chk = 0;
  int n_err = 0;

  usr_sipo_receiver #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .SI(SI), .SI_VLD(SI_VLD), .DIR(DIR), .CLR(CLR),
    .PO_RDY(PO_RDY), .PO(PO), .PO_VLD(PO_VLD), .BUSY(BUSY), .OVR(OVR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model: bits of the current word in arrival order plus the holding register.
  logic       mq[$];
  logic       m_dir;
  logic [7:0] m_po;
  logic       m_vld, m_ovr;

  task automatic model_reset();
    mq.delete();
    m_dir = 1'b0;
    m_po  = 8'h00;
    m_vld = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic vld, input logic si, input logic dir,
                            input logic clr, input logic rdy);
    logic [7:0] w;
    logic       accept;
    if (clr) begin
      model_reset();
    end else begin
      accept = m_vld && rdy;
      if (vld) begin
        if (mq.size() == 0) m_dir = dir;
        mq.push_back(si);
      end
      if (mq.size() == 8) begin
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (!m_dir) w[7-i] = mq[i];
          else        w[i]   = mq[i];
        end
        mq.delete();
        if (!m_vld || rdy) begin
          m_po  = w;
          m_vld = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (accept) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic vld, input logic si, input logic dir,
                      input logic clr, input logic rdy);
    SI_VLD = vld; SI = si; DIR = dir; CLR = clr; PO_RDY = rdy;
    model_step(vld, si, dir, clr, rdy);
    @(posedge CLK);
    #1;
    check("cyc_po", {24'h0, PO}, {24'h0, m_po});
    check("cyc_po_vld", {31'h0, PO_VLD}, {31'h0, m_vld});
    check("cyc_busy", {31'h0, BUSY}, {31'h0, (mq.size() != 0)});
    check("cyc_ovr", {31'h0, OVR}, {31'h0, m_ovr});
  endtask

  // seq[7] is sent first; PO_RDY is low except optionally on the last bit.
  task automatic send_word(input logic d, input logic [7:0] seq, input int max_gap,
                           input logic toggle, input logic rdy_last);
    logic cur;
    int   g;
    cur = d;
    for (int i = 0; i < 8; i++) begin
      if (toggle && i == 3) cur = ~cur;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) tick(1'b0, 1'b0, cur, 1'b0, 1'b0);
      tick(1'b1, seq[7-i], cur, 1'b0, (i == 7) ? rdy_last : 1'b0);
    end
  endtask

  task automatic drain();
    if (m_vld) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic       dir;
    logic [7:0] seq;
    logic [7:0] exp_po;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 8'hE5, 8'hE5};
    vecs[1] = '{1'b1, 8'hE5, 8'hA7};
    vecs[2] = '{1'b0, 8'h3C, 8'h3C};
    vecs[3] = '{1'b1, 8'h0F, 8'hF0};
    vecs[4] = '{1'b1, 8'h80, 8'h01};
    vecs[5] = '{1'b0, 8'h5A, 8'h5A};

    RST = 1'b0; SI = 1'b0; SI_VLD = 1'b0; DIR = 1'b0; CLR = 1'b0; PO_RDY = 1'b0;
    model_reset();
    #12;
    check("rst_po", {24'h0, PO}, 32'h0);
    check("rst_po_vld", {31'h0, PO_VLD}, 32'h0);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("rst_ovr", {31'h0, OVR}, 32'h0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // MSB-first word back to back; BUSY covered per cycle by the model.
    send_word(1'b0, 8'hE5, 0, 1'b0, 1'b0);
    check("msb_po", {24'h0, PO}, 32'hE5);
    check("msb_vld", {31'h0, PO_VLD}, 32'h1);
    check("msb_busy_done", {31'h0, BUSY}, 32'h0);
    drain();

    foreach (vecs[v]) begin
      drain();
      send_word(vecs[v].dir, vecs[v].seq, 2, 1'b0, 1'b0);
      check("tbl_po", {24'h0, PO}, {24'h0, vecs[v].exp_po});
      check("tbl_vld", {31'h0, PO_VLD}, 32'h1);
    end
    drain();

    // LSB-first with gaps and a DIR flip after bit 3.
    send_word(1'b1, 8'hE5, 3, 1'b1, 1'b0);
    check("lsb_toggle_po", {24'h0, PO}, 32'hA7);

    // Overrun.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(1'b0, 8'hE5, 1, 1'b0, 1'b0);
    send_word(1'b0, 8'h3C, 1, 1'b0, 1'b0);
    check("ovr_po_kept", {24'h0, PO}, 32'hE5);
    check("ovr_set", {31'h0, OVR}, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_accept_vld", {31'h0, PO_VLD}, 32'h0);
    check("ovr_sticky", {31'h0, OVR}, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_clr", {31'h0, OVR}, 32'h0);

    // Back-to-back with accept on the completion edge.
    send_word(1'b0, 8'h0F, 0, 1'b0, 1'b0);
    check("b2b_first", {24'h0, PO}, 32'h0F);
    send_word(1'b0, 8'hF0, 0, 1'b0, 1'b1);
    check("b2b_second", {24'h0, PO}, 32'hF0);
    check("b2b_vld", {31'h0, PO_VLD}, 32'h1);
    check("b2b_ovr", {31'h0, OVR}, 32'h0);

    // Asynchronous reset after four bits.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    SI_VLD = 1'b0; CLR = 1'b0; PO_RDY = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("arst_po", {24'h0, PO}, 32'h0);
    check("arst_vld", {31'h0, PO_VLD}, 32'h0);
    check("arst_busy", {31'h0, BUSY}, 32'h0);
    check("arst_ovr", {31'h0, OVR}, 32'h0);
    model_reset();
    #1 RST = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(1'b0, 8'hE5, 0, 1'b0, 1'b0);
    check("arst_then_word", {24'h0, PO}, 32'hE5);

    // CLR on bit 5, then a fresh word.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_mid_busy", {31'h0, BUSY}, 32'h0);
    send_word(1'b0, 8'hE5, 0, 1'b0, 1'b0);
    check("clr_then_word", {24'h0, PO}, 32'hE5);

    // CLR on the edge sampling bit 8.
    for (int i = 0; i < 7; i++) tick(1'b1, i[0], 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_cmp_vld", {31'h0, PO_VLD}, 32'h0);
    check("clr_cmp_po", {24'h0, PO}, 32'h0);
    check("clr_cmp_busy", {31'h0, BUSY}, 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(99, 0) < 70), 1'($urandom), 1'($urandom),
           ($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 30));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
